// File: rtl/mm_rd_if.sv
// Shared-read-port bundle between the ping/pong engines, the
// arbiter and the A/B operand memories.
interface mm_rd_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req0;
  logic          lock0;
  logic [AW-1:0] addra0;
  logic [AW-1:0] addrb0;
  logic          gnt0;
  logic          rvalid0;
  logic          req1;
  logic          lock1;
  logic [AW-1:0] addra1;
  logic [AW-1:0] addrb1;
  logic          gnt1;
  logic          rvalid1;
  logic          mem_en;
  logic [AW-1:0] mem_addra;
  logic [AW-1:0] mem_addrb;
  logic [DW-1:0] dina;
  logic [DW-1:0] dinb;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;
  logic          busy;

  modport slave (
    input  req0, lock0, addra0, addrb0,
    input  req1, lock1, addra1, addrb1,
    input  dina, dinb,
    output gnt0, rvalid0, gnt1, rvalid1,
    output mem_en, mem_addra, mem_addrb,
    output douta, doutb, busy
  );

  modport master (
    output req0, lock0, addra0, addrb0,
    output req1, lock1, addra1, addrb1,
    output dina, dinb,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  mem_en, mem_addra, mem_addrb,
    input  douta, doutb, busy
  );
endinterface

// File: rtl/mm_rd_arbiter.sv
// Two-requester read arbiter for the A/B operand memories:
// round robin with capped burst lock and a tagged return path.
module mm_rd_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic     clk,
  input  logic     rst,
  mm_rd_if.slave   bus
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_0    = 2'b01;
  localparam logic [1:0] OWN_1    = 2'b10;

  logic [1:0]        own_q, own_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              en_q;
  logic              tag_q;
  logic [AW-1:0]     ma_q, mb_q;
  logic [RD_LAT-1:0] pv_q, pid_q;

  logic              both;
  logic              own_lock;
  logic              keep;
  logic              g0, g1;
  logic              any_g;
  logic              same;
  logic              oth_req;
  logic [DW-1:0]     da_w, db_w;

  assign both = bus.req0 & bus.req1;

  always_comb begin
    own_lock = 1'b0;
    unique case (1'b1)
      own_q == OWN_0: own_lock = bus.lock0;
      own_q == OWN_1: own_lock = bus.lock1;
      default:        own_lock = 1'b0;
    endcase
  end

  // Lock only holds while the cap has room; at the cap the
  // round-robin leg hands the beat to the other side.
  assign keep = both & own_lock & (cnt_q < CW'(LOCK_MAX));

  assign g0 = ~rst & bus.req0
            & (~bus.req1 | (keep ? (own_q == OWN_0) : last_q));
  assign g1 = ~rst & bus.req1
            & (~bus.req0 | (keep ? (own_q == OWN_1) : ~last_q));

  assign any_g   = g0 | g1;
  assign same    = g1 ? (own_q == OWN_1) : (own_q == OWN_0);
  assign oth_req = g1 ? bus.req0 : bus.req1;

  always_comb begin
    own_d  = own_q;
    last_d = last_q;
    cnt_d  = '0;
    if (any_g) begin
      own_d  = g1 ? OWN_1 : OWN_0;
      last_d = g1;
      if (same & oth_req)
        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q  <= OWN_NONE;
      last_q <= 1'b1;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      tag_q  <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
    end else begin
      own_q  <= own_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      en_q   <= any_g;
      if (any_g) begin
        tag_q <= g1;
        ma_q  <= g1 ? bus.addra1 : bus.addra0;
        mb_q  <= g1 ? bus.addrb1 : bus.addrb0;
      end
    end
  end

  // Tag pipeline tracks the memory latency after mem_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q  <= '0;
      pid_q <= '0;
    end else begin
      pv_q[0]  <= en_q;
      pid_q[0] <= tag_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  assign da_w = bus.dina;
  assign db_w = bus.dinb;

  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.mem_en    = en_q;
  assign bus.mem_addra = ma_q;
  assign bus.mem_addrb = mb_q;
  assign bus.rvalid0   = pv_q[RD_LAT-1] & ~pid_q[RD_LAT-1];
  assign bus.rvalid1   = pv_q[RD_LAT-1] &  pid_q[RD_LAT-1];
  assign bus.douta     = da_w;
  assign bus.doutb     = db_w;
  assign bus.busy      = en_q | (|pv_q);

endmodule

// File: tb/tb_mm_rd_arbiter.sv
// Bench for mm_rd_arbiter: two instances (RD_LAT 1 and 3,
// LOCK_MAX 4) share stimulus; a scoreboard tracks every beat.
module tb_mm_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nt  = 0;
  int   nf  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mm_rd_if #(.AW(8), .DW(16)) if1 ();
  mm_rd_if #(.AW(8), .DW(16)) if3 ();

  mm_rd_arbiter #(.AW(8), .DW(16), .RD_LAT(1), .LOCK_MAX(4)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  mm_rd_arbiter #(.AW(8), .DW(16), .RD_LAT(3), .LOCK_MAX(4)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  function automatic logic [15:0] fa(input logic [7:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [15:0] fb(input logic [7:0] b);
    return {~b, b ^ 8'h5A};
  endfunction

  // Memory models: address registered RD_LAT times, data is a
  // fixed function of the address.
  logic [7:0] m1a, m1b;
  logic [7:0] m3a [3];
  logic [7:0] m3b [3];

  always @(posedge clk) begin
    m1a    <= if1.mem_addra;
    m1b    <= if1.mem_addrb;
    m3a[0] <= if3.mem_addra;
    m3b[0] <= if3.mem_addrb;
    m3a[1] <= m3a[0];
    m3b[1] <= m3b[0];
    m3a[2] <= m3a[1];
    m3b[2] <= m3b[1];
  end

  assign if1.dina = fa(m1a);
  assign if1.dinb = fb(m1b);
  assign if3.dina = fa(m3a[2]);
  assign if3.dinb = fb(m3b[2]);

  logic [1:0]  g_o  [2];
  logic [1:0]  rv_o [2];
  logic        en_o [2];
  logic        bs_o [2];
  logic [7:0]  ma_o [2];
  logic [7:0]  mb_o [2];
  logic [15:0] da_o [2];
  logic [15:0] db_o [2];

  assign g_o[0]  = {if1.gnt1, if1.gnt0};
  assign g_o[1]  = {if3.gnt1, if3.gnt0};
  assign rv_o[0] = {if1.rvalid1, if1.rvalid0};
  assign rv_o[1] = {if3.rvalid1, if3.rvalid0};
  assign en_o[0] = if1.mem_en;
  assign en_o[1] = if3.mem_en;
  assign bs_o[0] = if1.busy;
  assign bs_o[1] = if3.busy;
  assign ma_o[0] = if1.mem_addra;
  assign ma_o[1] = if3.mem_addra;
  assign mb_o[0] = if1.mem_addrb;
  assign mb_o[1] = if3.mem_addrb;
  assign da_o[0] = if1.douta;
  assign da_o[1] = if3.douta;
  assign db_o[0] = if1.doutb;
  assign db_o[1] = if3.doutb;

  typedef struct {
    int          k;
    int          gc;
    int          due;
    logic        id;
    logic [15:0] da;
    logic [15:0] db;
  } sb_t;

  sb_t        q[$];
  logic       exp_en = 1'b0;
  logic [7:0] exp_ma = 8'h00;
  logic [7:0] exp_mb = 8'h00;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nt++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s lat%0d cyc%0d obs=%0h exp=%0h",
             tag, lat(k), cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic l0,
                       input logic [7:0] a0,
                       input logic r1, input logic l1,
                       input logic [7:0] a1);
    if1.req0 = r0; if1.lock0 = l0;
    if1.addra0 = a0; if1.addrb0 = a0 ^ 8'hC3;
    if1.req1 = r1; if1.lock1 = l1;
    if1.addra1 = a1; if1.addrb1 = a1 ^ 8'hC3;
    if3.req0 = r0; if3.lock0 = l0;
    if3.addra0 = a0; if3.addrb0 = a0 ^ 8'hC3;
    if3.req1 = r1; if3.lock1 = l1;
    if3.addra1 = a1; if3.addrb1 = a1 ^ 8'hC3;
  endtask

  task automatic step(input logic r0, input logic l0,
                      input logic [7:0] a0,
                      input logic r1, input logic l1,
                      input logic [7:0] a1,
                      input logic [1:0] eg);
    logic [7:0] ga;
    drive(r0, l0, a0, r1, l1, a1);
    ga = eg[1] ? a1 : a0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int   idx;
      logic bexp;
      idx  = -1;
      bexp = 1'b0;
      chk("gnt", k, 32'(g_o[k]), 32'(eg));
      chk("mem_en", k, 32'(en_o[k]), 32'(exp_en));
      chk("mem_addra", k, 32'(ma_o[k]), 32'(exp_ma));
      chk("mem_addrb", k, 32'(mb_o[k]), 32'(exp_mb));
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].k == k) begin
          if (idx < 0) idx = i;
          if (q[i].gc < cyc) bexp = 1'b1;
        end
      end
      chk("busy", k, 32'(bs_o[k]), 32'(bexp));
      if (idx >= 0 && q[idx].due == cyc) begin
        chk("rvalid", k, 32'(rv_o[k]),
            q[idx].id ? 32'd2 : 32'd1);
        chk("douta", k, 32'(da_o[k]), 32'(q[idx].da));
        chk("doutb", k, 32'(db_o[k]), 32'(q[idx].db));
        q.delete(idx);
      end else begin
        chk("rvalid", k, 32'(rv_o[k]), 32'd0);
      end
      if (eg != 2'b00)
        q.push_back('{k: k, gc: cyc, due: cyc + 1 + lat(k),
                      id: eg[1], da: fa(ga),
                      db: fb(ga ^ 8'hC3)});
    end
    exp_en = (eg != 2'b00);
    if (eg != 2'b00) begin
      exp_ma = ga;
      exp_mb = ga ^ 8'hC3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 8'h00, 0, 0, 8'h00, 2'b00);
  endtask

  // Asserted away from the clock edge; inputs are left as they
  // are so the grant gating under reset is observed too.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt", k, 32'(g_o[k]), 32'd0);
      chk("rst_rvalid", k, 32'(rv_o[k]), 32'd0);
      chk("rst_mem_en", k, 32'(en_o[k]), 32'd0);
      chk("rst_mem_addra", k, 32'(ma_o[k]), 32'd0);
      chk("rst_mem_addrb", k, 32'(mb_o[k]), 32'd0);
      chk("rst_busy", k, 32'(bs_o[k]), 32'd0);
    end
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    q.delete();
    exp_en = 1'b0;
    exp_ma = 8'h00;
    exp_mb = 8'h00;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 4; i++)
      step(1, 0, 8'(i), 0, 0, 8'hEE, 2'b01);
    idle(5);

    do_reset();
    for (int i = 0; i < 8; i++)
      step(1, 0, 8'(8'h40 + i), 1, 0, 8'(8'h60 + i),
           (i % 2 == 1) ? 2'b10 : 2'b01);
    idle(5);

    do_reset();
    for (int i = 0; i < 12; i++)
      step(1, 1, 8'(8'h80 + i), 1, 0, 8'(8'hA0 + i),
           (i % 6 == 5) ? 2'b10 : 2'b01);
    idle(5);

    do_reset();
    for (int i = 0; i < 8; i++)
      step(1, 0, 8'h10, 1, 0, 8'h20,
           (i % 2 == 1) ? 2'b10 : 2'b01);
    idle(6);

    do_reset();
    step(1, 0, 8'h30, 0, 0, 8'h00, 2'b01);
    step(1, 0, 8'h31, 0, 0, 8'h00, 2'b01);
    do_reset();
    step(1, 0, 8'h50, 1, 0, 8'h70, 2'b01);
    step(1, 0, 8'h51, 1, 0, 8'h71, 2'b10);
    idle(6);

    do_reset();
    step(1, 0, 8'hC0, 0, 0, 8'h00, 2'b01);
    step(1, 0, 8'hC1, 1, 0, 8'hD1, 2'b10);
    step(1, 0, 8'hC2, 0, 0, 8'hD2, 2'b01);
    step(1, 0, 8'hC3, 0, 0, 8'hD3, 2'b01);
    step(1, 0, 8'hC4, 0, 0, 8'hD4, 2'b01);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule

// File: doc/mm_rd_arbiter.md
Name: mm_rd_arbiter

Overview:
- Shares the single read port of the A/B operand memories between two block-compute engines (ping and pong).
- Each engine issues (addra, addrb) read beats. The arbiter grants one beat per cycle, drives the shared memory address/enable registers, and returns read data tagged to the owner with a valid strobe.
- Lets both compute engines run overlapped (e.g. prefetch on one while the other finishes) without address-mux glitches on the memory port.

Parameters:
- AW, 8, address width of A and B memories.
- DW, 16, data width of A and B memories.
- RD_LAT, 1, memory read latency in cycles from mem_en to valid dina/dinb; legal range 1..4.
- LOCK_MAX, 16, maximum consecutive locked grants to one requester while the other is requesting.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 read-beat request.
- lock0  in  1  requester 0 burst-hold request; meaningful only with req0.
- addra0  in  AW  requester 0 A address.
- addrb0  in  AW  requester 0 B address.
- gnt0  out  1  beat accepted from requester 0 this cycle.
- rvalid0  out  1  douta/doutb belong to requester 0 this cycle.
- req1, lock1, addra1, addrb1, gnt1, rvalid1  same as above for requester 1.
- mem_en  out  1  memory read enable (registered).
- mem_addra  out  AW  A memory address (registered).
- mem_addrb  out  AW  B memory address (registered).
- dina  in  DW  A memory read data.
- dinb  in  DW  B memory read data.
- douta  out  DW  broadcast A read data (dina pass-through).
- doutb  out  DW  broadcast B read data (dinb pass-through).
- busy  out  1  any read in flight.

Behaviour:
- Reset values: gnt0/1=0, rvalid0/1=0, mem_en=0, mem_addra/b=0, busy=0, last_owner=1 (so requester 0 wins the first tie), owner=none, lock_cnt=0, tag pipeline cleared.
- Grant is combinational from req/lock/state:
  - Only one req high: that requester is granted.
  - Both high, current owner has lock asserted, lock_cnt<LOCK_MAX: owner keeps the grant.
  - Otherwise both high: grant goes to the requester != last_owner (round robin).
  - gnt0 and gnt1 are never high in the same cycle.
- On a grant in cycle t:
  - Next cycle: mem_en=1, mem_addra/b = granted addresses, tag = granted id.
  - With no grant, mem_en=0 and the addresses hold their last value.
- Tag pipeline: RD_LAT stages carrying valid+id. rvalidN is high in cycle t+1+RD_LAT exactly when the beat granted at t belonged to N. douta/doutb = dina/dinb combinationally.
- Throughput: one beat per cycle, back-to-back, across owner switches, with no bubbles.
- last_owner updates to the granted id on every grant.
- lock_cnt:
  - Increments when the owner is re-granted while the other requester is requesting.
  - Resets to 0 on an owner change or when the other requester is idle.
  - At LOCK_MAX the grant is forced to the other requester and lock_cnt clears.
- lock without req is ignored. A requester may drop req at any time; beats already granted still complete with rvalid.
- busy = any tag-pipeline valid or mem_en.
- Reset mid-operation: all in-flight beats are discarded and no rvalid is issued for them. The first grant after reset goes to requester 0 on a tie.
- Address inputs are sampled only in the granted cycle; requesters need not hold them afterwards.

Test Plan:
- Single requester: req0=1 for 4 cycles, addra0=0,1,2,3, RD_LAT=1 -> gnt0 high 4 cycles; mem_addra=0..3 on cycles 1..4; rvalid0 on cycles 2..5 with matching dina; rvalid1 never high.
- Tie, no lock: req0=req1=1 continuously -> grants alternate 0,1,0,1,...; first grant to 0; no idle cycles on mem_en.
- Lock with starvation cap, LOCK_MAX=4: lock0=1, req0=req1=1 -> exactly 5 consecutive gnt0 (1 initial + 4 locked), then one gnt1, then gnt0 again.
- Latency sweep RD_LAT=3: alternate beats with addresses 0x10/0x20 -> each rvalid appears exactly 4 cycles after its gnt with the correct id; data is model-checked.
- Reset mid-burst: assert rst with 2 beats in flight -> all outputs go to 0 immediately; no rvalid for the flushed beats; after release, a tie grants requester 0.
- Drop req after grant: req1 pulsed for 1 cycle while req0 streams -> gnt1 once; rvalid1 exactly once; busy falls 1+RD_LAT cycles after the last grant.
